regfile: RTL and testbench



---
 rtl/regfile.sv | 105 ++++++++++
 tb/tb_regfile.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// regfile: 32 x DATA_W general-purpose register file with hardwired-zero
// register 0, two combinational read ports and a HI/LO register pair.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read port
// returns the write-back data in the same cycle it is being written.
module regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              hilo_we,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    // GPR storage: cleared by reset, written at the clock edge unless the target is register 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the whole array is reset because every register must read
            // zero after reset; this keeps it in flops instead of a RAM macro.
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            // NOTE: non-blocking assignment, so every reader of regs in this
            // time step still sees the pre-edge value.
            regs[waddr] <= wdata;
        end
    end

    // HI/LO pair: always written together, never partially.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_we) begin
            hi <= hi_i;
            lo <= lo_i;
        end
    end

    // One read port: reset, disable and register 0 force zero, then the
    // optional same-cycle bypass, then stored contents.
    function automatic logic [DATA_W-1:0] read_port(
        input logic              re,
        input logic [ADDR_W-1:0] raddr
    );
        logic [DATA_W-1:0] data;
        data = '0;
        if (!rst && re && (raddr != '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (we && (waddr == raddr)) begin
                data = wdata;
            end else begin
                data = regs[raddr];
            end
`else
            data = regs[raddr];
`endif
        end
        return data;
    endfunction

    // Read port 1, purely combinational.
    always_comb begin
        // NOTE: a default on entry to every always_comb keeps each path
        // assigned, so no latch can be inferred.
        rdata1 = '0;
        rdata1 = read_port(re1, raddr1);
    end

    // Read port 2, purely combinational.
    always_comb begin
        rdata2 = '0;
        rdata2 = read_port(re2, raddr2);
    end

    // HI/LO outputs: zero while reset is held, otherwise the stored pair.
    always_comb begin
        hi_o = '0;
        lo_o = '0;
        if (!rst) begin
            hi_o = hi;
            lo_o = lo;
        end
    end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: scoreboard bench for regfile. The stimulus process drives one
// operation per cycle and pushes the expected outputs from a plain array
// model; a monitor pops and compares at every falling edge.
module tb_regfile;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic        re1 = 1'b0;
    logic [4:0]  raddr1 = '0;
    logic [31:0] rdata1;
    logic        re2 = 1'b0;
    logic [4:0]  raddr2 = '0;
    logic [31:0] rdata2;
    logic        hilo_we = 1'b0;
    logic [31:0] hi_i = '0;
    logic [31:0] lo_i = '0;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .hilo_we(hilo_we), .hi_i(hi_i), .lo_i(lo_i),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] r1;
        logic [31:0] r2;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: architectural state as a plain array.
    logic [31:0] m_regs [32];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    initial begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] <= '0;
            m_hi <= '0;
            m_lo <= '0;
        end else begin
            if (we && waddr != 5'd0) m_regs[waddr] <= wdata;
            if (hilo_we) begin
                m_hi <= hi_i;
                m_lo <= lo_i;
            end
        end
    end

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (rst || !re || a == 5'd0) return 32'h0;
        if (BYPASS && we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.name, ".rdata1"}, rdata1, e.r1);
            check({e.name, ".rdata2"}, rdata2, e.r2);
            check({e.name, ".hi_o"}, hi_o, e.hi);
            check({e.name, ".lo_o"}, lo_o, e.lo);
        end
    end

    task automatic issue(input string name);
        exp_t e;
        e.name = name;
        e.r1   = exp_read(re1, raddr1);
        e.r2   = exp_read(re2, raddr2);
        e.hi   = rst ? 32'h0 : m_hi;
        e.lo   = rst ? 32'h0 : m_lo;
        q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        we = 1'b0; hilo_we = 1'b0; re1 = 1'b0; re2 = 1'b0;
    endtask

    task automatic set_w(input logic w, input logic [4:0] a, input logic [31:0] d);
        we = w; waddr = a; wdata = d;
    endtask

    task automatic set_r(input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
        re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    endtask

    task automatic set_h(input logic w, input logic [31:0] h, input logic [31:0] l);
        hilo_we = w; hi_i = h; lo_i = l;
    endtask

    initial begin
        // Reset state
        next_cycle(); set_r(1, 5'd5, 1, 5'd7); issue("in_reset");
        next_cycle(); rst = 1'b0; set_r(1, 5'd5, 1, 5'd31); issue("after_reset");

        // Async reset clears a written register without a clock
        next_cycle(); set_w(1, 5'd5, 32'h12345678); issue("w5");
        next_cycle(); set_r(1, 5'd5, 0, 5'd0); issue("r5");
        next_cycle(); set_r(1, 5'd5, 1, 5'd5); #2 rst = 1'b1; issue("async_rst");
        next_cycle(); set_w(1, 5'd10, 32'hAAAA5555); set_h(1, 32'h1, 32'h2); issue("write_in_reset");
        next_cycle(); rst = 1'b0; set_r(1, 5'd5, 1, 5'd10); issue("post_rst_read");

        // Write then read, and a disabled port
        next_cycle(); set_w(1, 5'd7, 32'hDEADBEEF); issue("w7");
        next_cycle(); set_r(1, 5'd7, 1, 5'd7); issue("r7");
        next_cycle(); set_r(0, 5'd7, 1, 5'd7); issue("r7_re1_off");

        // Register 0 stays zero
        next_cycle(); set_w(1, 5'd0, 32'hFFFFFFFF); set_r(1, 5'd0, 1, 5'd0); issue("w0");
        next_cycle(); set_r(1, 5'd0, 1, 5'd0); issue("r0");

        // Same-cycle write/read hazard on register 3
        next_cycle(); set_w(1, 5'd3, 32'h11111111); issue("w3_old");
        next_cycle(); set_w(1, 5'd3, 32'h22222222); set_r(1, 5'd3, 1, 5'd3); issue("hazard_same_cycle");
        next_cycle(); set_r(1, 5'd3, 1, 5'd3); issue("hazard_after");

        // HI/LO write with concurrent GPR write
        next_cycle(); set_h(1, 32'hAAAA0000, 32'h0000BBBB); set_w(1, 5'd9, 32'h99); issue("hilo_w");
        next_cycle(); set_r(1, 5'd9, 0, 5'd0); issue("hilo_r");

        // Dual port, extreme addresses
        next_cycle(); set_w(1, 5'd1, 32'h1); issue("w1");
        next_cycle(); set_w(1, 5'd31, 32'hFFFFFFFE); issue("w31");
        next_cycle(); set_r(1, 5'd1, 1, 5'd31); issue("dual");

        // Randomized traffic, including occasional reset pulses
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa;
            next_cycle();
            rst = ($urandom_range(0, 49) == 0);
            wa  = 5'($urandom_range(0, 31));
            set_w(1'($urandom_range(0, 1)), wa, $urandom);
            set_r(1'($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 5) != 0),
                  ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            set_h(1'($urandom_range(0, 3) == 0), $urandom, $urandom);
            issue("rand");
        end

        next_cycle(); rst = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
